wb_spi_core: RTL and testbench
==============================

WB_SPI_CORE -- requirements
Module: wb_spi_core

Interface
REQ-001 SHALL have a single clock and a reset; reset is asynchronous and active-high.
REQ-002 CLK_48  in  1  system clock; all logic on rising edge.
REQ-003 rst  in  1  asynchronous active-high reset.
REQ-004 wb_adr  in  5  Wishbone byte address; decoded offsets 0x00, 0x10, 0x14, 0x18.
REQ-005 wb_di  in  32  write data from master.
REQ-006 wb_do  out  32  read data to master; valid while wb_ack=1.
REQ-007 wb_sel  in  4  byte enables; wb_sel[n] gates write of byte n.
REQ-008 wb_we, wb_stb, wb_cyc  in  1 each  write enable, strobe, cycle.
REQ-009 wb_ack  out  1  access complete for decoded address.
REQ-010 wb_err  out  1  access terminated on undecoded address.
REQ-011 wb_int  out  1  transfer-done interrupt, level.
REQ-012 sclk  out  1  SPI clock; idles low.
REQ-013 mosi  out  1  serial data out; miso  in  1  serial data in.
REQ-014 ss_n  out  8  active-low slave selects.

Function
REQ-015 Registers: 0x00 DATA (write = TX, read = RX), 0x10 CTRL, 0x14 DIVIDER[15:0], 0x18 SS[7:0]; unused bits read 0.
REQ-016 CTRL fields: [6:0] CHAR_LEN (0 = 32, values above 32 clamp to 32), [8] GO_BSY, [9] RX_NEG, [10] TX_NEG, [11] LSB, [12] IE, [13] ASS.
REQ-017 Access: wb_ack (or wb_err) asserts one cycle after wb_cyc&wb_stb is seen with both terminations low; held exactly one cycle; no new termination in the cycle after one.
REQ-018 Write takes effect on the edge that raises wb_ack; undecoded address raises wb_err instead; no register changes.
REQ-019 Writes to DATA, CTRL, DIVIDER while busy are acked and ignored; SS writes always accepted.
REQ-020 Writing CTRL with GO_BSY=1 starts a transfer; GO_BSY reads 1 until the last bit completes, then self-clears.
REQ-021 State machine: IDLE -> LOAD (one cycle: bit counter = CHAR_LEN, RX cleared, first bit on mosi) -> SHIFT (CHAR_LEN sclk periods) -> DONE (one cycle: clear GO_BSY, set wb_int if IE) -> IDLE.
REQ-022 sclk period = 2*(DIVIDER+1) CLK_48 cycles; DIVIDER=0 gives CLK_48/2; a transfer of N bits spans exactly N periods.
REQ-023 TX_NEG=0: mosi changes after rising sclk; TX_NEG=1: after falling sclk.
REQ-024 RX_NEG=0: miso sampled on rising sclk; RX_NEG=1: sampled on falling sclk.
REQ-025 LSB=0: TX bit CHAR_LEN-1 first, RX shifts in from bit 0 upward; LSB=1: bit 0 first, RX filled from bit CHAR_LEN-1 downward; RX bits >= CHAR_LEN read 0.
REQ-026 ss_n[i] = ~(SS[i] & (ASS ? busy : 1)).
REQ-027 wb_int clears on any acked Wishbone access; a transfer ending in the same cycle as an access leaves wb_int set.
REQ-028 mosi idles 0; sclk low in IDLE, LOAD, DONE.

Reset
REQ-029 rst forces: all registers 0, state IDLE, sclk=0, mosi=0, ss_n=8'hFF, wb_ack=0, wb_err=0, wb_int=0, wb_do=0.
REQ-030 rst mid-transfer aborts immediately; no wb_int, no partial RX retained.

Structure
REQ-031 Shared package holds register offsets, CTRL bit positions, state encodings, max CHAR_LEN (32).
REQ-032 One sub-module, spi_clgen: divider counter producing sclk and one-cycle pos/neg edge strobes, enabled only in SHIFT.

Verification
REQ-033 Write CTRL=0x3210, DIVIDER=16, SS=1; read back -> 0x3210, 0x10, 0x01; each access acked one cycle, wb_err=0.
REQ-034 TX=0xA500, CTRL=0x3310 (16 bits, RX_NEG, IE, ASS, GO), miso loops mosi -> ss_n=8'hFE only while busy, 16 periods of 34 cycles, wb_int=1, RX read 0xA500, wb_int clears.
REQ-035 LSB=1, CHAR_LEN=8, TX=0x01 -> first mosi bit 1, RX bits [31:8]=0.
REQ-036 Write DATA=0xFFFF mid-transfer -> acked, TX unchanged, result unaffected.
REQ-037 Access address 0x04 -> wb_err one cycle, wb_ack=0, registers unchanged.
REQ-038 Assert rst at bit 5 of a transfer -> ss_n=8'hFF, sclk=0 same cycle, wb_int never set.

Source files
------------

// File: rtl/wb_spi_core_pkg.sv
// wb_spi_core_pkg: register map, CTRL field positions, FSM encoding, length helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wb_spi_core_pkg;

  // Byte offsets of the decoded registers
  localparam logic [4:0] ADR_DATA = 5'h00;
  localparam logic [4:0] ADR_CTRL = 5'h10;
  localparam logic [4:0] ADR_DIV  = 5'h14;
  localparam logic [4:0] ADR_SS   = 5'h18;

  // CTRL bit positions; CHAR_LEN occupies [6:0]
  localparam int CTRL_GO     = 8;
  localparam int CTRL_RX_NEG = 9;
  localparam int CTRL_TX_NEG = 10;
  localparam int CTRL_LSB    = 11;
  localparam int CTRL_IE     = 12;
  localparam int CTRL_ASS    = 13;

  localparam int MAX_CHAR_LEN = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } spi_state_e;

  // Effective character length: 0 and anything above the maximum mean a full word
  function automatic logic [5:0] eff_len(input logic [6:0] char_len);
    logic [5:0] len;
    len = char_len[5:0];
    if (char_len == 7'd0 || char_len > 7'(MAX_CHAR_LEN)) len = 6'(MAX_CHAR_LEN);
    return len;
  endfunction

endpackage

// File: rtl/wb_spi_core_if.sv
// wb_spi_core_if: Wishbone slave bus plus the transfer-done interrupt line.
// Latency: n/a (wiring only).
// Backpressure: master holds cyc/stb until ack or err returns.
interface wb_spi_core_if;
  logic [4:0]  wb_adr;
  logic [31:0] wb_di;
  logic [31:0] wb_do;
  logic [3:0]  wb_sel;
  logic        wb_we;
  logic        wb_stb;
  logic        wb_cyc;
  logic        wb_ack;
  logic        wb_err;
  logic        wb_int;

  modport master (
    output wb_adr, wb_di, wb_sel, wb_we, wb_stb, wb_cyc,
    input  wb_do, wb_ack, wb_err, wb_int
  );

  modport slave (
    input  wb_adr, wb_di, wb_sel, wb_we, wb_stb, wb_cyc,
    output wb_do, wb_ack, wb_err, wb_int
  );
endinterface

// File: rtl/wb_spi_core_clgen.sv
// spi_clgen: divides the core clock into sclk, period 2*(div+1), with edge strobes.
// Latency: strobes are high in the cycle whose closing edge toggles sclk.
// Backpressure: none; disabling forces sclk low and reloads the divider.
module spi_clgen (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [15:0] div_i,
  output logic        sclk_o,
  output logic        pos_o,
  output logic        neg_o
);

  logic [15:0] cnt_q, cnt_d;
  logic        sclk_q, sclk_d;
  logic        tick;

  assign tick = en_i && (cnt_q == 16'd0);

  // Divider countdown: reload and toggle sclk on terminal count, park low when disabled
  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (!en_i) begin
      cnt_d  = div_i;
      sclk_d = 1'b0;
    end else if (tick) begin
      cnt_d  = div_i;
      sclk_d = ~sclk_q;
    end else begin
      cnt_d = cnt_q - 16'd1;
    end
  end

  // Divider state registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= 16'd0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk_o = sclk_q;
  assign pos_o  = tick & ~sclk_q;
  assign neg_o  = tick & sclk_q;

endmodule

// File: rtl/wb_spi_core.sv
// wb_spi_core: Wishbone-programmed SPI master, 1..32-bit characters, 8 slave selects.
// Latency: ack/err one cycle after a fresh cyc&stb; transfer = 3 + 2*N*(DIVIDER+1) cycles.
// Backpressure: accesses never stall; DATA/CTRL/DIVIDER writes while busy are acked and dropped.
module wb_spi_core
  import wb_spi_core_pkg::*;
(
  input  logic         CLK_48,
  input  logic         rst,
  wb_spi_core_if.slave wb,
  output logic         sclk,
  output logic         mosi,
  input  logic         miso,
  output logic [7:0]   ss_n
);

  // Programmable registers
  logic [31:0] tx_q, tx_d;
  logic [31:0] rx_q, rx_d;
  logic [13:0] ctrl_q, ctrl_d;
  logic [15:0] div_q, div_d;
  logic [7:0]  ss_q, ss_d;

  // Bus-side state
  logic        ack_q, err_q, int_q, int_d;
  logic [31:0] do_q, do_d;

  // Transfer engine
  spi_state_e  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [4:0]  idx_q, idx_d;
  logic        mosi_q, mosi_d;

  logic        busy, req, hit, acc, wr;
  logic [31:0] rd_dat;
  logic [5:0]  len;
  logic [4:0]  len_m1;
  logic        clk_en, sck, sck_pos, sck_neg;
  logic        fsm_load, fsm_done;
  logic        tx_edge, rx_edge, tx_adv;
  logic [4:0]  idx_sel, tx_pos;
  logic [31:0] rx_shr;

  assign busy   = ctrl_q[CTRL_GO];
  assign len    = eff_len(ctrl_q[6:0]);
  assign len_m1 = 5'(len - 6'd1);

  // A new request is only taken when no termination is showing this cycle
  assign req = wb.wb_cyc & wb.wb_stb & ~ack_q & ~err_q;
  assign hit = (wb.wb_adr == ADR_DATA) || (wb.wb_adr == ADR_CTRL) ||
               (wb.wb_adr == ADR_DIV)  || (wb.wb_adr == ADR_SS);
  assign acc = req & hit;
  assign wr  = acc & wb.wb_we;

  // Read mux; DATA reads return the receive register
  always_comb begin
    rd_dat = 32'd0;
    case (wb.wb_adr)
      ADR_DATA: rd_dat = rx_q;
      ADR_CTRL: rd_dat = {18'd0, ctrl_q};
      ADR_DIV:  rd_dat = {16'd0, div_q};
      ADR_SS:   rd_dat = {24'd0, ss_q};
      default:  rd_dat = 32'd0;
    endcase
  end

  // Register writes with byte enables; SS is the only register writable while busy
  always_comb begin
    tx_d   = tx_q;
    ctrl_d = ctrl_q;
    div_d  = div_q;
    ss_d   = ss_q;
    if (wr && !busy && wb.wb_adr == ADR_DATA) begin
      for (int b = 0; b < 4; b++) begin
        if (wb.wb_sel[b]) tx_d[8*b +: 8] = wb.wb_di[8*b +: 8];
      end
    end
    if (wr && !busy && wb.wb_adr == ADR_CTRL) begin
      if (wb.wb_sel[0]) ctrl_d[6:0]  = wb.wb_di[6:0];
      if (wb.wb_sel[1]) ctrl_d[13:8] = wb.wb_di[13:8];
    end
    if (wr && !busy && wb.wb_adr == ADR_DIV) begin
      if (wb.wb_sel[0]) div_d[7:0]  = wb.wb_di[7:0];
      if (wb.wb_sel[1]) div_d[15:8] = wb.wb_di[15:8];
    end
    if (wr && wb.wb_adr == ADR_SS && wb.wb_sel[0]) ss_d = wb.wb_di[7:0];
    if (fsm_done) ctrl_d[CTRL_GO] = 1'b0;
  end

  // Read data and interrupt; a finishing transfer wins over a same-cycle clear
  always_comb begin
    do_d = 32'd0;
    if (acc && !wb.wb_we) do_d = rd_dat;
    int_d = int_q;
    if (acc) int_d = 1'b0;
    if (fsm_done && ctrl_q[CTRL_IE]) int_d = 1'b1;
  end

  assign clk_en = (state_q == ST_SHIFT);

  // Transfer FSM next state and one-cycle LOAD/DONE actions
  always_comb begin
    state_d  = state_q;
    fsm_load = 1'b0;
    fsm_done = 1'b0;
    case (state_q)
      ST_IDLE:  if (busy) state_d = ST_LOAD;
      ST_LOAD: begin
        fsm_load = 1'b1;
        state_d  = ST_SHIFT;
      end
      ST_SHIFT: if (sck_neg && cnt_q == 6'd1) state_d = ST_DONE;
      ST_DONE: begin
        fsm_done = 1'b1;
        state_d  = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  assign tx_edge = ctrl_q[CTRL_TX_NEG] ? sck_neg : sck_pos;
  assign rx_edge = ctrl_q[CTRL_RX_NEG] ? sck_neg : sck_pos;
  // Bit 0 goes out in LOAD, so a rising-edge launch skips the first rising edge;
  // a falling-edge launch stops once the last bit is on the wire
  assign tx_adv  = ctrl_q[CTRL_TX_NEG] ? (idx_q != len_m1) : (cnt_q != len);
  assign idx_sel = fsm_load ? 5'd0 : idx_q + 5'd1;
  assign tx_pos  = ctrl_q[CTRL_LSB] ? idx_sel : len_m1 - idx_sel;

  // LSB-first receive enters at the top of the character and walks down
  always_comb begin
    rx_shr         = rx_q >> 1;
    rx_shr[len_m1] = miso;
  end

  // Shift datapath: period counter, launch index, mosi and receive register
  always_comb begin
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    mosi_d = mosi_q;
    rx_d   = rx_q;
    if (fsm_load) begin
      cnt_d  = len;
      idx_d  = 5'd0;
      mosi_d = tx_q[tx_pos];
      rx_d   = 32'd0;
    end else if (state_q == ST_SHIFT) begin
      if (sck_neg) cnt_d = cnt_q - 6'd1;
      if (tx_edge && tx_adv) begin
        idx_d  = idx_sel;
        mosi_d = tx_q[tx_pos];
      end
      if (rx_edge) rx_d = ctrl_q[CTRL_LSB] ? rx_shr : {rx_q[30:0], miso};
    end else begin
      mosi_d = 1'b0;
    end
  end

  // Register file and shift datapath state
  always_ff @(posedge CLK_48 or posedge rst) begin
    if (rst) begin
      tx_q   <= 32'd0;
      rx_q   <= 32'd0;
      ctrl_q <= 14'd0;
      div_q  <= 16'd0;
      ss_q   <= 8'd0;
      cnt_q  <= 6'd0;
      idx_q  <= 5'd0;
      mosi_q <= 1'b0;
    end else begin
      tx_q   <= tx_d;
      rx_q   <= rx_d;
      ctrl_q <= ctrl_d;
      div_q  <= div_d;
      ss_q   <= ss_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      mosi_q <= mosi_d;
    end
  end

  // FSM state register
  always_ff @(posedge CLK_48 or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Bus terminations, read data and interrupt
  always_ff @(posedge CLK_48 or posedge rst) begin
    if (rst) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      do_q  <= 32'd0;
      int_q <= 1'b0;
    end else begin
      ack_q <= acc;
      err_q <= req & ~hit;
      do_q  <= do_d;
      int_q <= int_d;
    end
  end

  spi_clgen u_clgen (
    .clk_i  (CLK_48),
    .rst_i  (rst),
    .en_i   (clk_en),
    .div_i  (div_q),
    .sclk_o (sck),
    .pos_o  (sck_pos),
    .neg_o  (sck_neg)
  );

  assign sclk      = sck;
  assign mosi      = mosi_q;
  assign ss_n      = ~(ss_q & (ctrl_q[CTRL_ASS] ? {8{busy}} : 8'hFF));
  assign wb.wb_ack = ack_q;
  assign wb.wb_err = err_q;
  assign wb.wb_do  = do_q;
  assign wb.wb_int = int_q;

endmodule

// File: tb/tb_wb_spi_core.sv
// tb_wb_spi_core: directed Wishbone/SPI vectors with mosi looped back to miso.
// Latency: checks single-cycle termination and transfer cycle counts.
// Backpressure: every wait on the DUT is bounded.
module tb_wb_spi_core;
  import wb_spi_core_pkg::*;

  logic       CLK_48 = 1'b0;
  logic       rst    = 1'b1;
  logic       sclk, mosi, miso;
  logic [7:0] ss_n;

  int checks = 0;
  int errors = 0;

  wb_spi_core_if wb ();

  assign miso = mosi;

  wb_spi_core dut (
    .CLK_48 (CLK_48),
    .rst    (rst),
    .wb     (wb),
    .sclk   (sclk),
    .mosi   (mosi),
    .miso   (miso),
    .ss_n   (ss_n)
  );

  always #10 CLK_48 = ~CLK_48;

  // Free-running pin monitor sampled mid-cycle; phases take differences
  int   ss_cnt   = 0;
  int   hi_cnt   = 0;
  int   rise_cnt = 0;
  logic sclk_prev = 1'b0;
  always @(negedge CLK_48) begin
    if (ss_n == 8'hFE) ss_cnt++;
    if (sclk) hi_cnt++;
    if (sclk && !sclk_prev) rise_cnt++;
    sclk_prev = sclk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic wb_acc(input string tag, input logic we, input logic [4:0] adr,
                        input logic [31:0] dat, output logic [31:0] rdat,
                        output logic ack, output logic err);
    int lat;
    @(posedge CLK_48); #1;
    wb.wb_cyc = 1'b1; wb.wb_stb = 1'b1; wb.wb_we = we;
    wb.wb_adr = adr;  wb.wb_di  = dat;  wb.wb_sel = 4'hF;
    lat = 0;
    do begin
      @(posedge CLK_48); #1;
      lat++;
    end while (!(wb.wb_ack || wb.wb_err) && lat < 20);
    ack  = wb.wb_ack;
    err  = wb.wb_err;
    rdat = wb.wb_do;
    check({tag, "_lat"}, lat, 1);
    wb.wb_cyc = 1'b0; wb.wb_stb = 1'b0; wb.wb_we = 1'b0;
    @(posedge CLK_48); #1;
    check({tag, "_hold"}, {30'd0, wb.wb_ack, wb.wb_err}, 32'd0);
  endtask

  task automatic wb_wr(input string tag, input logic [4:0] adr, input logic [31:0] dat);
    logic [31:0] rd;
    logic ack, err;
    wb_acc(tag, 1'b1, adr, dat, rd, ack, err);
    check({tag, "_term"}, {30'd0, ack, err}, 32'd2);
  endtask

  task automatic wb_rd(input string tag, input logic [4:0] adr, input logic [31:0] exp);
    logic [31:0] rd;
    logic ack, err;
    wb_acc(tag, 1'b0, adr, 32'd0, rd, ack, err);
    check({tag, "_term"}, {30'd0, ack, err}, 32'd2);
    check({tag, "_dat"}, rd, exp);
  endtask

  task automatic wait_int(input string tag);
    int n = 0;
    while (!wb.wb_int && n < 2000) begin
      @(posedge CLK_48); #1;
      n++;
    end
    check({tag, "_int"}, {31'd0, wb.wb_int}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int ss0, hi0, r0, n;
    logic seen;
    logic [31:0] rd;
    logic ack, err;
    wb.wb_cyc = 1'b0; wb.wb_stb = 1'b0; wb.wb_we = 1'b0;
    wb.wb_adr = 5'd0; wb.wb_di  = 32'd0; wb.wb_sel = 4'h0;

    // Reset values
    repeat (3) @(posedge CLK_48);
    #1;
    check("rst_ss_n", {24'd0, ss_n}, 32'h0000_00FF);
    check("rst_pins", {30'd0, sclk, mosi}, 32'd0);
    check("rst_wbout", {29'd0, wb.wb_ack, wb.wb_err, wb.wb_int}, 32'd0);
    check("rst_do", wb.wb_do, 32'd0);
    rst = 1'b0;
    wb_rd("rst_ctrl", ADR_CTRL, 32'd0);

    // Register write/readback
    wb_wr("w_ctrl", ADR_CTRL, 32'h0000_3210);
    wb_wr("w_div",  ADR_DIV,  32'h0000_0010);
    wb_wr("w_ss",   ADR_SS,   32'h0000_0001);
    wb_rd("r_ctrl", ADR_CTRL, 32'h0000_3210);
    wb_rd("r_div",  ADR_DIV,  32'h0000_0010);
    wb_rd("r_ss",   ADR_SS,   32'h0000_0001);
    check("ass_idle_ss_n", {24'd0, ss_n}, 32'h0000_00FF);

    // Undecoded address terminates with err and changes nothing
    wb_acc("bad_adr", 1'b1, 5'h04, 32'hFFFF_FFFF, rd, ack, err);
    check("bad_adr_term", {30'd0, ack, err}, 32'd1);
    wb_rd("bad_ctrl", ADR_CTRL, 32'h0000_3210);
    wb_rd("bad_div",  ADR_DIV,  32'h0000_0010);

    // 16-bit MSB-first transfer, sample on falling, auto slave select
    wb_wr("t1_tx", ADR_DATA, 32'h0000_A500);
    ss0 = ss_cnt; hi0 = hi_cnt; r0 = rise_cnt;
    wb_wr("t1_go", ADR_CTRL, 32'h0000_3310);
    wait_int("t1");
    check("t1_ss_cycles",   ss_cnt - ss0,   547);
    check("t1_sclk_hi",     hi_cnt - hi0,   272);
    check("t1_sclk_rises",  rise_cnt - r0,  16);
    check("t1_ss_after", {24'd0, ss_n}, 32'h0000_00FF);
    wb_rd("t1_rx", ADR_DATA, 32'h0000_A500);
    check("t1_int_clr", {31'd0, wb.wb_int}, 32'd0);
    wb_rd("t1_ctrl", ADR_CTRL, 32'h0000_3210);

    // DATA write while busy is acked and ignored
    wb_wr("t2_tx", ADR_DATA, 32'h0000_1234);
    wb_wr("t2_go", ADR_CTRL, 32'h0000_1310);
    repeat (100) @(posedge CLK_48);
    wb_wr("t2_busy_wr", ADR_DATA, 32'h0000_FFFF);
    wait_int("t2");
    wb_rd("t2_rx", ADR_DATA, 32'h0000_1234);
    wb_rd("t2_ctrl", ADR_CTRL, 32'h0000_1210);

    // 8-bit LSB-first, launch on falling, sample on rising
    wb_wr("t3_tx", ADR_DATA, 32'hFFFF_FF01);
    wb_wr("t3_go", ADR_CTRL, 32'h0000_1D08);
    repeat (3) @(posedge CLK_48);
    #1;
    check("t3_first_mosi", {30'd0, mosi, sclk}, 32'd2);
    wait_int("t3");
    wb_rd("t3_rx", ADR_DATA, 32'h0000_0001);

    // Reset in the middle of a transfer
    wb_wr("t4_tx", ADR_DATA, 32'h0000_00FF);
    r0 = rise_cnt;
    wb_wr("t4_go", ADR_CTRL, 32'h0000_3108);
    n = 0;
    while ((rise_cnt - r0) < 5 && n < 1000) begin
      @(posedge CLK_48); #1;
      n++;
    end
    check("t4_bit5_reached", rise_cnt - r0, 5);
    check("t4_ss_pre", {24'd0, ss_n}, 32'h0000_00FE);
    rst = 1'b1;
    #1;
    check("t4_ss_rst",   {24'd0, ss_n}, 32'h0000_00FF);
    check("t4_sclk_rst", {31'd0, sclk}, 32'd0);
    repeat (2) @(posedge CLK_48);
    #1;
    rst  = 1'b0;
    seen = 1'b0;
    repeat (600) begin
      @(posedge CLK_48); #1;
      seen = seen | wb.wb_int | sclk;
    end
    check("t4_quiet", {31'd0, seen}, 32'd0);
    wb_rd("t4_rx",   ADR_DATA, 32'd0);
    wb_rd("t4_ctrl", ADR_CTRL, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
